// File: rtl/sys_ctrl_axil_regs_if.sv
// AXI4-Lite bus bundle for the SYS_CTRL responder; signal suffixes are from the responder's side.
interface sys_ctrl_axil_regs_if;
    logic [31:0] awaddr_i;
    logic        awvalid_i;
    logic        awready_o;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        wvalid_i;
    logic        wready_o;
    logic [1:0]  bresp_o;
    logic        bvalid_o;
    logic        bready_i;
    logic [31:0] araddr_i;
    logic        arvalid_i;
    logic        arready_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic        rvalid_o;
    logic        rready_i;

    modport slave (
        input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        output awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
    );

    modport master (
        output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
               araddr_i, arvalid_i, rready_i,
        input  awready_o, wready_o, bresp_o, bvalid_o, arready_o, rdata_o, rresp_o, rvalid_o
    );
endinterface

// File: rtl/sys_ctrl_axil_regs.sv
// SYS_CTRL register file behind an AXI4-Lite responder: domain clock/reset controls,
// boot addresses, boot hart IDs and PLL words, driven out as static controls.
module sys_ctrl_axil_regs #(
    parameter logic [31:0] BOOT_ADDR_E_RST = 32'h0900_0000,
    parameter logic [31:0] BOOT_ADDR_P_RST = 32'h0800_0000,
    parameter logic [31:0] HARTID_E_RST    = 32'd0,
    parameter logic [31:0] HARTID_P_RST    = 32'd1
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    sys_ctrl_axil_regs_if.slave          bus,
    output logic                         e_core_clk_en_o,
    output logic                         e_core_rst_o,
    output logic                         p_core_clk_en_o,
    output logic                         p_core_rst_o,
    output logic                         core_link_clk_en_o,
    output logic                         core_link_rst_o,
    output logic                         sys_link_clk_en_o,
    output logic                         sys_link_rst_o,
    output logic                         periph_link_clk_en_o,
    output logic                         periph_link_rst_o,
    output logic [31:0]                  boot_addr_e_core_o,
    output logic [31:0]                  boot_addr_p_core_o,
    output logic [31:0]                  boot_hartid_e_core_o,
    output logic [31:0]                  boot_hartid_p_core_o,
    output logic [31:0]                  pll_cfg_e_core_o,
    output logic [31:0]                  pll_cfg_p_core_o,
    output logic [31:0]                  pll_cfg_sys_link_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    // ctl_q index = offset[4:2]: E_CORE, P_CORE, CORE_LINK, SYS_LINK, PERIPH_LINK; bit0 clk_en, bit1 rst
    logic [4:0][1:0]  ctl_q;
    logic [1:0][31:0] boot_q;
    logic [1:0][31:0] hart_q;
    logic [2:0][31:0] pll_q;

    w_state_e    w_state_q;
    logic        aw_got_q, w_got_q;
    logic [11:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;

    r_state_e    r_state_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic        aw_hs, w_hs, wr_commit, wr_ok, rd_ok;
    logic [11:0] wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;
    logic [3:0]  wr_strb;
    logic        unused_addr_bits;

    function automatic logic addr_ok(input logic [11:0] a);
        case (a)
            12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
            12'h040, 12'h044, 12'h080, 12'h084,
            12'h0C0, 12'h0C4, 12'h0CC: addr_ok = 1'b1;
            default:                   addr_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    assign unused_addr_bits = ^{bus.awaddr_i[31:12], bus.araddr_i[31:12]};

    assign bus.awready_o = (w_state_q == W_IDLE) && !aw_got_q;
    assign bus.wready_o  = (w_state_q == W_IDLE) && !w_got_q;
    assign bus.bvalid_o  = bvalid_q;
    assign bus.bresp_o   = bresp_q;
    assign bus.arready_o = (r_state_q == R_IDLE);
    assign bus.rvalid_o  = rvalid_q;
    assign bus.rresp_o   = rresp_q;
    assign bus.rdata_o   = rdata_q;

    assign aw_hs = bus.awvalid_i && bus.awready_o;
    assign w_hs  = bus.wvalid_i && bus.wready_o;

    // Use a channel captured earlier, otherwise the one handshaking this cycle
    assign wr_addr   = aw_got_q ? awaddr_q : bus.awaddr_i[11:0];
    assign wr_data   = w_got_q  ? wdata_q  : bus.wdata_i;
    assign wr_strb   = w_got_q  ? wstrb_q  : bus.wstrb_i;
    assign wr_commit = (w_state_q == W_IDLE) && (aw_got_q || aw_hs) && (w_got_q || w_hs);
    assign wr_ok     = addr_ok(wr_addr);

    assign rd_addr = bus.araddr_i[11:0];
    assign rd_ok   = addr_ok(rd_addr);

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            12'h000, 12'h004, 12'h008, 12'h00C, 12'h010: rd_data = {30'b0, ctl_q[rd_addr[4:2]]};
            12'h040, 12'h044: rd_data = boot_q[rd_addr[2]];
            12'h080, 12'h084: rd_data = hart_q[rd_addr[2]];
            12'h0C0:          rd_data = pll_q[0];
            12'h0C4:          rd_data = pll_q[1];
            12'h0CC:          rd_data = pll_q[2];
            default:          rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ctl_q  <= {2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
            boot_q <= {BOOT_ADDR_P_RST, BOOT_ADDR_E_RST};
            hart_q <= {HARTID_P_RST, HARTID_E_RST};
            pll_q  <= '0;
        end else if (wr_commit && wr_ok) begin
            case (wr_addr)
                12'h000, 12'h004, 12'h008, 12'h00C, 12'h010:
                    if (wr_strb[0]) ctl_q[wr_addr[4:2]] <= wr_data[1:0];
                12'h040, 12'h044: boot_q[wr_addr[2]] <= merge(boot_q[wr_addr[2]], wr_data, wr_strb);
                12'h080, 12'h084: hart_q[wr_addr[2]] <= merge(hart_q[wr_addr[2]], wr_data, wr_strb);
                12'h0C0:          pll_q[0] <= merge(pll_q[0], wr_data, wr_strb);
                12'h0C4:          pll_q[1] <= merge(pll_q[1], wr_data, wr_strb);
                12'h0CC:          pll_q[2] <= merge(pll_q[2], wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            w_state_q <= W_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got_q <= 1'b1;
                        awaddr_q <= bus.awaddr_i[11:0];
                    end
                    if (w_hs) begin
                        w_got_q <= 1'b1;
                        wdata_q <= bus.wdata_i;
                        wstrb_q <= bus.wstrb_i;
                    end
                    if (wr_commit) begin
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.bready_i) begin
                        bvalid_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (bus.arvalid_i) begin
                        rdata_q   <= rd_ok ? rd_data : 32'h0;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.rready_i) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign e_core_clk_en_o      = ctl_q[0][0];
    assign e_core_rst_o         = ctl_q[0][1];
    assign p_core_clk_en_o      = ctl_q[1][0];
    assign p_core_rst_o         = ctl_q[1][1];
    assign core_link_clk_en_o   = ctl_q[2][0];
    assign core_link_rst_o      = ctl_q[2][1];
    assign sys_link_clk_en_o    = ctl_q[3][0];
    assign sys_link_rst_o       = ctl_q[3][1];
    assign periph_link_clk_en_o = ctl_q[4][0];
    assign periph_link_rst_o    = ctl_q[4][1];
    assign boot_addr_e_core_o   = boot_q[0];
    assign boot_addr_p_core_o   = boot_q[1];
    assign boot_hartid_e_core_o = hart_q[0];
    assign boot_hartid_p_core_o = hart_q[1];
    assign pll_cfg_e_core_o     = pll_q[0];
    assign pll_cfg_p_core_o     = pll_q[1];
    assign pll_cfg_sys_link_o   = pll_q[2];
endmodule

// File: doc/sys_ctrl_axil_regs.md
Name: sys_ctrl_axil_regs

Overview:
AXI4-Lite responder for the 4 KiB SYS_CTRL window at 0x0000_2000–0x0000_2FFF, attached to master port 0 of the peripheral link.
Holds the system control register file: per-domain clock-enable/reset controls, boot addresses, boot hart IDs and PLL configuration words.
Drives those values as static outputs to the clock/reset and core subsystems.
Reads and writes are handled independently; one outstanding transaction per direction.

Parameters:
BOOT_ADDR_E_RST  'h0900_0000  reset value of BOOT_ADDR_E_CORE (boot ROM base)
BOOT_ADDR_P_RST  'h0800_0000  reset value of BOOT_ADDR_P_CORE (P-core DTCM base)
HARTID_E_RST     0            reset value of BOOT_HARTID_E_CORE
HARTID_P_RST     1            reset value of BOOT_HARTID_P_CORE

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active-high
awaddr_i  in  32  write address
awvalid_i / awready_o  in/out  1  AW handshake
wdata_i  in  32  write data
wstrb_i  in  4  byte strobes
wvalid_i / wready_o  in/out  1  W handshake
bresp_o  out  2  write response (OKAY=0, SLVERR=2)
bvalid_o / bready_i  out/in  1  B handshake
araddr_i  in  32  read address
arvalid_i / arready_o  in/out  1  AR handshake
rdata_o  out  32  read data
rresp_o  out  2  read response
rvalid_o / rready_i  out/in  1  R handshake
e_core_clk_en_o, e_core_rst_o  out  1  E-core domain control
p_core_clk_en_o, p_core_rst_o  out  1  P-core domain control
core_link_clk_en_o, core_link_rst_o  out  1  core link control
sys_link_clk_en_o, sys_link_rst_o  out  1  system link control
periph_link_clk_en_o, periph_link_rst_o  out  1  peripheral link control
boot_addr_e_core_o, boot_addr_p_core_o  out  32  boot addresses
boot_hartid_e_core_o, boot_hartid_p_core_o  out  32  boot hart IDs
pll_cfg_e_core_o, pll_cfg_p_core_o, pll_cfg_sys_link_o  out  32  PLL config words

Behaviour:
- Decode uses addr[11:0]; upper bits are ignored.
- Map:
  - 0x000 E_CORE_CLK_RST, 0x004 P_CORE_CLK_RST, 0x008 CORE_LINK_CLK_RST, 0x00C SYS_LINK_CLK_RST, 0x010 PERIPH_LINK_CLK_RST
  - 0x040/0x044 BOOT_ADDR E/P
  - 0x080/0x084 BOOT_HARTID E/P
  - 0x0C0/0x0C4/0x0CC PLL_CFG E/P/SYS_LINK
- CLK_RST registers: bit0 = clk_en, bit1 = rst. Bits [31:2] read 0, writes to them are ignored.
- All other registers are 32-bit R/W.
- Reset values:
  - E_CORE = 0x1; P_CORE = 0x2 (P-core gated and held in reset); all three LINK registers = 0x1
  - BOOT_ADDR, HARTID: per parameters; PLL_CFG: 0
- Outputs are direct register bits, with no extra latency.
- Unmapped offset or addr[1:0] != 0 → SLVERR. Writes to such addresses have no effect; reads return rdata = 0.
- Write path FSM W_IDLE → W_RESP:
  - awready_o = wready_o = 1 in W_IDLE for any channel not yet captured. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - In the cycle both are held, the write commits per wstrb. Strobe 0 leaves the byte unchanged; wstrb = 0 is OKAY with no change.
  - bvalid_o rises in the next cycle and is held with stable bresp_o until bready_i, then the FSM returns to W_IDLE. AW/W are not accepted in W_RESP.
  - Minimum latency: AW+W handshake in cycle N → bvalid in cycle N+1.
- Read path FSM R_IDLE → R_RESP:
  - arready_o = 1 in R_IDLE. On handshake, rdata/rresp are registered and rvalid_o rises in the next cycle.
  - rdata/rresp are held stable until rready_i, then the FSM returns to R_IDLE.
- Read/write collision on the same register in the same cycle: the read returns the pre-write value.
- Reset values after arst_i:
  - bvalid_o = rvalid_o = 0; awready_o = wready_o = arready_o = 1; bresp/rresp/rdata = 0
  - all registers at reset values, including when arst_i is asserted mid-transaction. The pending response is dropped.
- periph_link_rst_o is asserted by this block's own writes and does not reset this block. Firmware is responsible for not isolating the bus it is using.

Test Plan:
1. Release arst_i, then read every mapped offset → OKAY. 0x040 = 0x0900_0000, 0x044 = 0x0800_0000, 0x084 = 1, 0x004 = 0x2, 0x000 = 0x1; output ports match.
2. AW to 0x004 in cycle 0, W 0xFFFF_FFFD/strb 0xF in cycle 3 → bvalid in cycle 4, OKAY. p_core_clk_en_o = 1, p_core_rst_o = 0; readback = 0x1.
3. Write 0xAABB_CCDD strb 0x5 to 0x0C0 (prior 0) → readback 0x00BB_00DD; pll_cfg_e_core_o follows.
4. Read 0x100, write 0x0C8, read 0x042 → SLVERR each; rdata 0; no register changes.
5. Hold bready_i/rready_i low for 5 cycles → bvalid/rvalid and data stay stable; no new AW/AR accepted until release.
6. Assert arst_i during W_RESP after a write of 0x1234 to 0x040 → bvalid_o drops immediately; 0x040 reads 0x0900_0000 after reset.
